// File: rtl/sfx_sequencer_pkg.sv
// Shared note divisors, jingle lengths and state encoding for the sfx sequencer.
// Divisors are clk/freq at 100 MHz; REST_DIV silences the buzzer.
package sfx_pkg;

  localparam int NOTE_W = 22;
  localparam int IDX_W  = 3;

  typedef logic [NOTE_W-1:0] note_t;
  typedef logic [IDX_W-1:0]  idx_t;

  localparam note_t REST_DIV = 22'd0;
  localparam note_t C4       = 22'd381679;
  localparam note_t D4       = 22'd340136;
  localparam note_t E4       = 22'd303030;
  localparam note_t F4       = 22'd286533;
  localparam note_t G4       = 22'd255102;
  localparam note_t C5       = 22'd191204;
  localparam note_t E5       = 22'd151745;
  localparam note_t G5       = 22'd127551;
  localparam note_t C6       = 22'd95511;

  localparam int LIGHT_LEN = 4;
  localparam int DEAD_LEN  = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PLAY_LIGHT = 2'd1,
    ST_PLAY_DEAD  = 2'd2
  } state_t;

  // Doubling the divisor drops one octave; every table entry leaves the MSB clear.
  function automatic note_t octave_down(input note_t n);
    return {n[NOTE_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/sfx_sequencer_if.sv
// Game-event inputs and per-channel note outputs of the sfx sequencer.
// The game side is the master; the sequencer is the slave.
interface sfx_sequencer_if;
  import sfx_pkg::*;

  logic  light;
  logic  dead;
  note_t out_note_left;
  note_t out_note_right;
  logic  busy;

  modport master (
    output light,
    output dead,
    input  out_note_left,
    input  out_note_right,
    input  busy
  );

  modport slave (
    input  light,
    input  dead,
    output out_note_left,
    output out_note_right,
    output busy
  );

endinterface

// File: rtl/sfx_sequencer_beat_timer.sv
// Beat timer: counts 0..BEAT_DIV-1, flags the final count with o_beat_tick.
// Synchronous clear restarts the beat so the next tick is a full BEAT_DIV clocks away.
module beat_timer #(
  parameter int BEAT_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_beat_tick
);

  localparam int CNT_W = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEAT_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last      = (r_cnt == LAST);
  assign o_beat_tick = w_last & ~i_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sfx_sequencer.sv
// Turns light/dead event edges into timed two-channel jingles, one note per beat.
// Outputs registered: first note appears one clock after the triggering edge.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int BEAT_DIV = 12_500_000
) (
  input  logic           clk,
  input  logic           rst,
  sfx_sequencer_if.slave bus
);

  localparam idx_t LIGHT_LAST = idx_t'(LIGHT_LEN - 1);
  localparam idx_t DEAD_LAST  = idx_t'(DEAD_LEN - 1);

  state_t r_state;
  idx_t   r_idx;
  logic   r_light_q;
  logic   r_dead_q;
  note_t  r_left;
  note_t  r_right;
  logic   r_busy;

  logic   w_light_rise;
  logic   w_dead_rise;
  logic   w_dead_go;
  logic   w_light_go;
  logic   w_beat_tick;
  logic   w_timer_clr;
  logic   w_last_idx;
  idx_t   w_next_idx;
  note_t  w_next_left;
  note_t  w_next_right;

  function automatic note_t light_note(input idx_t idx);
    case (idx)
      3'd0:    return C5;
      3'd1:    return E5;
      3'd2:    return G5;
      3'd3:    return C6;
      default: return REST_DIV;
    endcase
  endfunction

  function automatic note_t dead_note(input idx_t idx);
    case (idx)
      3'd0:    return G4;
      3'd1:    return F4;
      3'd2:    return E4;
      3'd3:    return D4;
      3'd4:    return C4;
      3'd5:    return REST_DIV;
      3'd6:    return C4;
      default: return REST_DIV;
    endcase
  endfunction

  assign w_light_rise = bus.light & ~r_light_q;
  assign w_dead_rise  = bus.dead & ~r_dead_q;

  // A death jingle is never interrupted, not even by another death event.
  assign w_dead_go  = w_dead_rise & (r_state != ST_PLAY_DEAD);
  assign w_light_go = w_light_rise & ~w_dead_rise & (r_state != ST_PLAY_DEAD);

  // Holding the timer cleared while idle makes beat 0 a full beat long.
  assign w_timer_clr = (r_state == ST_IDLE) | w_dead_go | w_light_go;

  beat_timer #(
    .BEAT_DIV (BEAT_DIV)
  ) u_beat_timer (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_timer_clr),
    .o_beat_tick (w_beat_tick)
  );

  always_comb begin
    w_next_idx   = r_idx + idx_t'(1);
    w_last_idx   = 1'b0;
    w_next_left  = REST_DIV;
    w_next_right = REST_DIV;
    if (r_state == ST_PLAY_DEAD) begin
      w_last_idx   = (r_idx == DEAD_LAST);
      w_next_left  = dead_note(w_next_idx);
      w_next_right = octave_down(w_next_left);
    end else if (r_state == ST_PLAY_LIGHT) begin
      w_last_idx   = (r_idx == LIGHT_LAST);
      w_next_left  = light_note(w_next_idx);
      w_next_right = w_next_left;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_light_q <= 1'b1;
      r_dead_q  <= 1'b1;
      r_left    <= REST_DIV;
      r_right   <= REST_DIV;
      r_busy    <= 1'b0;
    end else begin
      r_light_q <= bus.light;
      r_dead_q  <= bus.dead;
      if (w_dead_go) begin
        r_state <= ST_PLAY_DEAD;
        r_idx   <= '0;
        r_left  <= dead_note('0);
        r_right <= octave_down(dead_note('0));
        r_busy  <= 1'b1;
      end else if (w_light_go) begin
        r_state <= ST_PLAY_LIGHT;
        r_idx   <= '0;
        r_left  <= light_note('0);
        r_right <= light_note('0);
        r_busy  <= 1'b1;
      end else if (w_beat_tick && (r_state != ST_IDLE)) begin
        if (w_last_idx) begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_left  <= REST_DIV;
          r_right <= REST_DIV;
          r_busy  <= 1'b0;
        end else begin
          r_idx   <= w_next_idx;
          r_left  <= w_next_left;
          r_right <= w_next_right;
        end
      end
    end
  end

  assign bus.out_note_left  = r_left;
  assign bus.out_note_right = r_right;
  assign bus.busy           = r_busy;

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Event-driven sound-effect sequencer for the crossy_road audio path. It sits directly upstream of the per-channel buzzer controllers. It turns the game's `light` and `dead` event inputs into timed jingles, presenting one 22-bit note divisor per channel (`out_note_left`, `out_note_right`) that changes once per beat. When idle it outputs the rest divisor, so the buzzers stay silent.

## Interface
- `BEAT_DIV`, default 12_500_000: clocks per beat (8 beats/s at 100 MHz). Must be ≥2. Benches use 4.
- `clk` input 1: system clock, 100 MHz.
- `rst` input 1: synchronous, active-high reset.
- `light` input 1: level from game logic. A rising edge requests the light jingle.
- `dead` input 1: level from game logic. A rising edge requests the death jingle.
- `out_note_left` output 22: left note divisor (clk/freq). `REST_DIV` = 0 means silence.
- `out_note_right` output 22: right note divisor. Same encoding.
- `busy` output 1: high while a jingle is playing.

## Operation
- Edge detect: registers `light_q` and `dead_q`.
  - `light_rise = light & ~light_q`; `dead_rise = dead & ~dead_q`.
  - Both registers reset to 1, so a level already high at reset release does not trigger.
- States:
  - IDLE: outputs `REST_DIV`; `busy` = 0.
  - PLAY_LIGHT: 4 beats, index 0..3.
  - PLAY_DEAD: 8 beats, index 0..7.
- Light table, left = right:
  - C5 191204, E5 151745, G5 127551, C6 95511.
- Dead table, left channel:
  - G4 255102, F4 286533, E4 303030, D4 340136, C4 381679, REST, C4 381679, REST.
  - Right channel = left << 1 (one octave down); REST stays 0. The maximum 763358 fits in 22 bits. No truncation is allowed.
- Transitions:
  - `dead_rise` in any state → PLAY_DEAD, index 0, beat counter 0. Exception: already in PLAY_DEAD, in which case the event is ignored and there is no restart.
  - `light_rise` in IDLE or PLAY_LIGHT → PLAY_LIGHT, index 0, counter 0 (restart). It is ignored in PLAY_DEAD.
  - If `dead_rise` and `light_rise` occur in the same cycle, `dead` wins.
  - When the beat counter reaches `BEAT_DIV`-1 the index increments. On the last index the block returns to IDLE.
  - A new trigger arriving on a terminal beat cycle takes precedence over the advance or the return to IDLE.
- `rst` mid-jingle forces IDLE on the next edge: index 0, counter 0, outputs `REST_DIV`, `busy` 0.

## Timing
- All outputs are registered.
- Reset values:
  - `out_note_left` = `out_note_right` = 0.
  - `busy` = 0.
  - State IDLE, index 0, counter 0.
  - `light_q` = `dead_q` = 1.
- Latency: an input that is high at edge k and was low at edge k-1 produces note 0 on the outputs after edge k. That is a 1-clock latency; `busy` rises on the same edge.
- Each beat holds exactly `BEAT_DIV` clocks, including beat 0.
- Light jingle: 4×`BEAT_DIV` clocks from its trigger edge to `busy` falling. Dead jingle: 8×`BEAT_DIV`.
- On the edge that leaves the last beat, outputs go to 0 and `busy` falls together.
- Outputs change only on beat boundaries, triggers, or reset. There are no glitches between beats.

## Structure
- `sfx_pkg` holds:
  - the note divisor constants (`C4`..`C6`, `REST_DIV` = 22'd0);
  - the jingle lengths (`LIGHT_LEN` = 4, `DEAD_LEN` = 8);
  - the state encoding.
- Sub-module `beat_timer`:
  - counts from 0 to `BEAT_DIV`-1;
  - takes a synchronous clear input and produces a one-cycle `beat_tick`.
- The sequencer FSM and the note ROMs (case statements on the index) live in `sfx_sequencer`.

## Test plan
- Reset with `dead` held high, then release and hold 20 cycles → no trigger: outputs 0, `busy` 0.
- `light` rising edge, `BEAT_DIV`=4 → outputs follow 191204, 151745, 127551, 95511, 4 clocks each, from 1 clock after the edge. Outputs return to 0 and `busy` falls 16 clocks after the trigger edge.
- `dead` rising edge → left follows 255102, 286533, 303030, 340136, 381679, 0, 381679, 0; right = 2× left (763358 for C4). 32 clocks total.
- `dead` rises during light beat 2 → PLAY_DEAD index 0 on the next edge. A `light` pulse during the death jingle and a second `dead` edge are both ignored; the jingle completes its 32 clocks.
- `light` and `dead` rise on the same cycle → death jingle. Then `light` re-triggered mid light-jingle → restart at 191204 with a full 16-clock duration.
- `rst` asserted at death beat 3 → outputs 0 and `busy` 0 after the next edge. A fresh `light` edge afterwards plays normally.
